// File: rtl/panel_io_pkg.sv
// panel_io_pkg: shared types and sizing helpers for the front-panel frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package panel_io_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_GAP
    } state_t;

    localparam int DEF_OUT_BITS = 32;
    localparam int DEF_IN_BITS  = 24;

    // Shift phase length: both chain types share one bit clock, so the frame
    // runs for the longer of the two chains.
    function automatic int max_bits(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/panel_io_scheduler_tick_divider.sv
// tick_divider: 1-cycle strobe every DIV clk cycles, phase held at zero while clear is high.
// Latency: first tick DIV cycles after clear drops.
// Backpressure: none; free-running once released.
// Ports: clk, reset (sync, active-high), clear (hold phase at 0), tick (strobe out).
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/panel_io_scheduler.sv
// panel_io_scheduler: one combined frame drives two 595 lamp chains and samples three 165 switch chains.
// Latency: frame = (4 + 2*N + GAP)*DIV cycles; switch words publish STABLE_FRAMES frames after settling.
// Backpressure: none; enable is a level, a running frame always completes before going idle.
// Ports: clk, reset, enable, out_data_0/1 (lamp words), qh_0..2 (165 serial in),
//        srclk, rclk, sh_ldn, ser_0/1 (chain pins), in_data_0..2 + in_valid (debounced switches), busy.
module panel_io_scheduler
    import panel_io_pkg::*;
#(
    parameter int OUT_BITS      = DEF_OUT_BITS,
    parameter int IN_BITS       = DEF_IN_BITS,
    parameter int DIV           = 4,
    parameter int GAP           = 2,
    parameter int STABLE_FRAMES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [OUT_BITS-1:0] out_data_0,
    input  logic [OUT_BITS-1:0] out_data_1,
    input  logic                qh_0,
    input  logic                qh_1,
    input  logic                qh_2,
    output logic                srclk,
    output logic                rclk,
    output logic                sh_ldn,
    output logic                ser_0,
    output logic                ser_1,
    output logic [IN_BITS-1:0]  in_data_0,
    output logic [IN_BITS-1:0]  in_data_1,
    output logic [IN_BITS-1:0]  in_data_2,
    output logic                in_valid,
    output logic                busy
);

    localparam int              N        = max_bits(OUT_BITS, IN_BITS);
    localparam int              KW       = $clog2(N + 1);
    localparam logic [KW-1:0]   K_LAST   = KW'(N - 1);
    localparam logic [KW-1:0]   K_IN     = KW'(IN_BITS);
    localparam int              MW       = $clog2(STABLE_FRAMES + 1);
    localparam logic [MW-1:0]   M_LAST   = MW'(STABLE_FRAMES - 1);
    localparam int              HCW      = (GAP > 2) ? $clog2(GAP) : 1;
    localparam logic [HCW-1:0]  GAP_LAST = HCW'((GAP > 0) ? GAP - 1 : 0);

    state_t              state;
    logic [HCW-1:0]      hc;        // half-period count inside LOAD/LATCH/GAP
    logic                high;      // SHIFT: 0 = low half, 1 = high half
    logic [KW-1:0]       k;         // SHIFT bit index
    logic [OUT_BITS-1:0] shadow_0, shadow_1;
    logic [IN_BITS-1:0]  cap_0, cap_1, cap_2;
    logic [IN_BITS-1:0]  prev_0, prev_1, prev_2;
    logic [MW-1:0]       match;
    logic                tick;

    tick_divider #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state == S_IDLE),
        .tick  (tick)
    );

    logic          latch_end;
    logic          end_frame;
    logic [MW-1:0] match_nxt;
    logic          publish;

    always_comb begin
        latch_end = tick && (state == S_LATCH) && hc[0];
        end_frame = (tick && (state == S_GAP) && (hc == GAP_LAST)) ||
                    ((GAP == 0) && latch_end);
        match_nxt = '0;
        if ({cap_2, cap_1, cap_0} == {prev_2, prev_1, prev_0}) begin
            match_nxt = (match == M_LAST) ? M_LAST : match + 1'b1;
        end
        // Only publish a stable word that actually differs from what is out there.
        publish = (match_nxt == M_LAST) &&
                  ({cap_2, cap_1, cap_0} != {in_data_2, in_data_1, in_data_0});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            hc        <= '0;
            high      <= 1'b0;
            k         <= '0;
            srclk     <= 1'b0;
            rclk      <= 1'b0;
            sh_ldn    <= 1'b1;
            ser_0     <= 1'b0;
            ser_1     <= 1'b0;
            busy      <= 1'b0;
            in_valid  <= 1'b0;
            in_data_0 <= '0;
            in_data_1 <= '0;
            in_data_2 <= '0;
            shadow_0  <= '0;
            shadow_1  <= '0;
            cap_0     <= '0;
            cap_1     <= '0;
            cap_2     <= '0;
            prev_0    <= '0;
            prev_1    <= '0;
            prev_2    <= '0;
            match     <= '0;
        end else begin
            in_valid <= 1'b0;

            if (latch_end) begin
                match  <= match_nxt;
                prev_0 <= cap_0;
                prev_1 <= cap_1;
                prev_2 <= cap_2;
                if (publish) begin
                    in_data_0 <= cap_0;
                    in_data_1 <= cap_1;
                    in_data_2 <= cap_2;
                    in_valid  <= 1'b1;
                end
            end

            if (end_frame) begin
                hc <= '0;
                if (enable) begin
                    // Back-to-back frame: busy stays high, lamps resnapshot here.
                    state    <= S_LOAD;
                    sh_ldn   <= 1'b0;
                    shadow_0 <= out_data_0;
                    shadow_1 <= out_data_1;
                end else begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (enable) begin
                            state    <= S_LOAD;
                            busy     <= 1'b1;
                            sh_ldn   <= 1'b0;
                            shadow_0 <= out_data_0;
                            shadow_1 <= out_data_1;
                            hc       <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (tick) begin
                            if (!hc[0]) begin
                                sh_ldn <= 1'b1;
                                hc     <= HCW'(1);
                            end else begin
                                // Present bit 0 for the first low half; shadow drains MSB first
                                // and feeds zeros once a shorter lamp chain is exhausted.
                                state    <= S_SHIFT;
                                hc       <= '0;
                                high     <= 1'b0;
                                k        <= '0;
                                ser_0    <= shadow_0[OUT_BITS-1];
                                ser_1    <= shadow_1[OUT_BITS-1];
                                shadow_0 <= shadow_0 << 1;
                                shadow_1 <= shadow_1 << 1;
                            end
                        end
                    end
                    S_SHIFT: begin
                        if (tick) begin
                            if (!high) begin
                                // Sample QH before the rising edge shifts the 165s.
                                if (k < K_IN) begin
                                    cap_0 <= {cap_0[IN_BITS-2:0], qh_0};
                                    cap_1 <= {cap_1[IN_BITS-2:0], qh_1};
                                    cap_2 <= {cap_2[IN_BITS-2:0], qh_2};
                                end
                                srclk <= 1'b1;
                                high  <= 1'b1;
                            end else begin
                                srclk <= 1'b0;
                                high  <= 1'b0;
                                if (k == K_LAST) begin
                                    state <= S_LATCH;
                                    rclk  <= 1'b1;
                                    ser_0 <= 1'b0;
                                    ser_1 <= 1'b0;
                                    hc    <= '0;
                                end else begin
                                    k        <= k + 1'b1;
                                    ser_0    <= shadow_0[OUT_BITS-1];
                                    ser_1    <= shadow_1[OUT_BITS-1];
                                    shadow_0 <= shadow_0 << 1;
                                    shadow_1 <= shadow_1 << 1;
                                end
                            end
                        end
                    end
                    S_LATCH: begin
                        if (tick) begin
                            if (!hc[0]) begin
                                rclk <= 1'b0;
                                hc   <= HCW'(1);
                            end else begin
                                state <= S_GAP;
                                hc    <= '0;
                            end
                        end
                    end
                    S_GAP: begin
                        if (tick) begin
                            hc <= hc + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_panel_io_scheduler.sv
// tb_panel_io_scheduler: directed vectors with 595/165 chain models and a lamp/switch scoreboard.
// Latency: checks rclk timing, publish timing and frame length against hand-computed cycle counts.
// Backpressure: n/a.
module tb_panel_io_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] out_data_0, out_data_1;
    logic        qh_0, qh_1, qh_2;
    logic        srclk, rclk, sh_ldn, ser_0, ser_1;
    logic [23:0] in_data_0, in_data_1, in_data_2;
    logic        in_valid, busy;

    panel_io_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .out_data_0 (out_data_0),
        .out_data_1 (out_data_1),
        .qh_0       (qh_0),
        .qh_1       (qh_1),
        .qh_2       (qh_2),
        .srclk      (srclk),
        .rclk       (rclk),
        .sh_ldn     (sh_ldn),
        .ser_0      (ser_0),
        .ser_1      (ser_1),
        .in_data_0  (in_data_0),
        .in_data_1  (in_data_1),
        .in_data_2  (in_data_2),
        .in_valid   (in_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    int start       = 0;

    // 165 chain models: parallel load while sh_ldn low, shift on srclk rise.
    logic [23:0] ch0_val, ch1_val, ch2_val;
    logic [23:0] sr165_0 = '0, sr165_1 = '0, sr165_2 = '0;
    always @(negedge sh_ldn or posedge srclk) begin
        if (!sh_ldn) begin
            sr165_0 <= ch0_val;
            sr165_1 <= ch1_val;
            sr165_2 <= ch2_val;
        end else begin
            sr165_0 <= sr165_0 << 1;
            sr165_1 <= sr165_1 << 1;
            sr165_2 <= sr165_2 << 1;
        end
    end
    assign qh_0 = sr165_0[23];
    assign qh_1 = sr165_1[23];
    assign qh_2 = sr165_2[23];

    // 595 chain models.
    logic [31:0] sr595_0 = '0, sr595_1 = '0, lat_0 = '0, lat_1 = '0;
    always @(posedge srclk) begin
        sr595_0 <= {sr595_0[30:0], ser_0};
        sr595_1 <= {sr595_1[30:0], ser_1};
    end
    always @(posedge rclk) begin
        lat_0 <= sr595_0;
        lat_1 <= sr595_1;
    end

    logic [63:0] exp_lamp[$];
    logic [71:0] exp_in[$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT latches lamps or publishes switches.
    logic rclk_q    = 1'b0;
    int   last_rclk = -1000;
    always @(negedge clk) begin
        if (!reset) begin
            if (rclk && !rclk_q) begin
                last_rclk <= cyc;
                if (exp_lamp.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rclk: got rclk rise at cycle %0d expected none", cyc);
                end else begin
                    check("lamp_latch", {lat_1, lat_0}, exp_lamp.pop_front());
                end
            end
            if (in_valid) begin
                if (exp_in.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_in_valid: got pulse with %h expected none",
                             {in_data_2, in_data_1, in_data_0});
                end else begin
                    check("in_data_publish", {in_data_2, in_data_1, in_data_0}, exp_in.pop_front());
                    check("in_valid_delay", cyc - last_rclk, 8);
                end
            end
            if (srclk && rclk) begin
                miscompares++;
                $display("FAIL pin_overlap: got srclk=1 rclk=1 at cycle %0d expected not both", cyc);
            end
            if (!sh_ldn && srclk) begin
                miscompares++;
                $display("FAIL load_overlap: got sh_ldn=0 srclk=1 at cycle %0d expected not both", cyc);
            end
        end
        rclk_q <= rclk;
    end

    task automatic goto(input int rel);
        while (cyc - start < rel) @(negedge clk);
    endtask

    task automatic wait_rclk(input string name, input int exp_rel);
        int   n;
        logic prev;
        prev = rclk;
        for (n = 0; n < 600; n++) begin
            @(negedge clk);
            if (rclk && !prev) break;
            prev = rclk;
        end
        check(name, (n < 600) ? 96'(cyc - start) : '1, 96'(exp_rel));
    endtask

    task automatic wait_idle(input string name, input int exp_rel);
        int n;
        for (n = 0; n < 600; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(name, (n < 600) ? 96'(cyc - start) : '1, 96'(exp_rel));
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_pins"}, {srclk, rclk, sh_ldn, ser_0, ser_1, in_valid, busy}, 7'b0010000);
        check({name, "_in_data"}, {in_data_2, in_data_1, in_data_0}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish within 20000 cycles");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        out_data_0 = '0;
        out_data_1 = '0;
        ch0_val    = 24'hA5A5A5;
        ch1_val    = 24'h000000;
        ch2_val    = 24'hFFF000;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        // Stable switches, lamp snapshot, mid-frame lamp change, enable drop.
        out_data_0 = 32'h8000_0001;
        out_data_1 = 32'h0000_0000;
        repeat (3) exp_lamp.push_back({32'h0000_0000, 32'h8000_0001});
        exp_in.push_back({24'hFFF000, 24'h000000, 24'hA5A5A5});
        enable = 1'b1;
        start  = cyc + 1;
        goto(100);
        check("busy_in_frame", busy, 1);
        wait_rclk("first_rclk_cycle", 264);
        goto(660);
        out_data_0 = 32'h1234_5678;
        out_data_1 = 32'hCAFE_F00D;
        exp_lamp.push_back({32'hCAFE_F00D, 32'h1234_5678});
        goto(940);
        enable = 1'b0;
        goto(1119);
        check("busy_before_end", busy, 1);
        goto(1120);
        check("busy_after_gap", busy, 0);
        check("pins_idle", {srclk, rclk, sh_ldn, ser_1, ser_0}, 5'b00100);
        goto(1200);
        check("stays_idle", {busy, srclk, sh_ldn}, 3'b001);
        check("in_data_held", {in_data_2, in_data_1, in_data_0}, {24'hFFF000, 24'h000000, 24'hA5A5A5});
        check("lamp_q_drained", exp_lamp.size(), 0);
        check("in_q_drained", exp_in.size(), 0);

        // Reset in the middle of SHIFT.
        enable = 1'b1;
        start  = cyc + 1;
        goto(150);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_shift_reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Clean restart with chain 0 toggling every frame: never stable.
        out_data_0 = 32'h0F0F_0F0F;
        out_data_1 = 32'hFFFF_0000;
        ch0_val    = 24'hA5A5A5;
        repeat (4) exp_lamp.push_back({32'hFFFF_0000, 32'h0F0F_0F0F});
        enable = 1'b1;
        start  = cyc + 1;
        goto(100);
        ch0_val = 24'h5A5A5A;
        wait_rclk("rerun_first_rclk", 264);
        goto(380);
        ch0_val = 24'hA5A5A5;
        wait_rclk("rerun_second_rclk", 544);
        goto(660);
        ch0_val = 24'h5A5A5A;
        goto(940);
        enable = 1'b0;
        wait_idle("rerun_frame_end", 1120);
        check("toggle_in_data_0", in_data_0, 24'h000000);
        check("toggle_lamp_q_drained", exp_lamp.size(), 0);
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
